address_counter_n: RTL and testbench
====================================

Name: address_counter_n

Overview:
- Parameterised N-bit address counter that advances by one on every clock where its count-enable input `d` is high.
- Wraps from MAX_ADDRESS back to 0.
- Used as the buffer/memory address generator in the UART datapath; `d` is the per-word strobe from the upstream receiver/transmitter control.

Parameters:
- N, 2, width of the address output in bits (N >= 1).
- MAX_ADDRESS, 3, highest address value before wrap to 0. Must satisfy 0 <= MAX_ADDRESS <= 2^N - 1. Values outside this range are a configuration error (elaboration-time assertion).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset. Sampled on the clk rising edge; no asynchronous path.
- d  input  1  count enable. Level-sensitive, sampled on each clk rising edge.
- address  output  N  current address. Registered output driven directly from the count register, with no combinational path from `d`.

Behaviour:
- Single register `count[N-1:0]`; `address = count`.
- Priority at each rising clk edge:
  1. rst low -> count <= 0, regardless of `d`.
  2. Else d high and count == MAX_ADDRESS -> count <= 0 (wrap).
  3. Else d high -> count <= count + 1.
  4. Else -> hold.
- Reset value: address = 0, visible after the first rising edge with rst low.
- Before the first reset edge the output is undefined. No initial value is relied upon.
- Latency: address reflects an accepted `d` one clock after the edge that sampled it; no pipeline beyond that.
- Level-sensitive counting: `d` held high for K consecutive edges advances the count K times, modulo (MAX_ADDRESS + 1). It is not edge-detected, so upstream logic must pulse `d` for exactly one cycle per increment.
- Wrap: the sequence is 0, 1, ..., MAX_ADDRESS, 0, ...
- With MAX_ADDRESS < 2^N - 1, values above MAX_ADDRESS are never reached from reset.
- If such a value is present anyway (X-propagation or illegal state), the next enabled edge loads 0. Compare as count >= MAX_ADDRESS for robustness.
- Reset mid-count: rst low on any edge forces 0 on that edge, even when `d` is high on the same edge.
- When rst returns high, counting resumes from 0 on the first edge with `d` high.
- Arithmetic is unsigned N-bit; no carry or overflow output.
- Purely synchronous single-clock design; no latches, no gated clocks.

Test Plan:
- Reset: N=2, MAX_ADDRESS=3, rst=0, d=0 for 1+ edges -> address == 0. Release rst=1 with d=0 for 2 edges -> address stays 0.
- Single-step: pulse d=1 for one cycle, then d=0 for one cycle -> address == 1 after the pulse and still 1 after the idle cycle. Repeat for 2 and 3, checking the hold each time.
- Wrap: at address == 3, pulse d for one cycle -> address == 0; idle cycle -> still 0.
- Continuous enable: d held high for 10 edges from 0 -> sequence 1, 2, 3, 0, 1, 2, 3, 0, 1, 2.
- Reset priority: at address == 2, drive rst=0 and d=1 on the same edge -> address == 0. Release rst with d=1 -> next edge address == 1.
- Non-power-of-two wrap: N=3, MAX_ADDRESS=5, d held high from reset -> 1, 2, 3, 4, 5, 0, 1. Values 6 and 7 are never observed.

Source files
------------

// File: rtl/address_counter_n.sv
// address_counter_n: N-bit wrapping address generator for the UART datapath.
// Advances by one on every rising clk edge where d is high, and wraps from
// MAX_ADDRESS back to 0. rst is synchronous and active-low. address is taken
// straight from the count register, so there is no combinational path from d.
module address_counter_n #(
  parameter int N           = 2,
  parameter int MAX_ADDRESS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d,
  output logic [N-1:0] address
);

  // Largest value an N-bit count can hold. Worked out in 64 bits so that the
  // shift cannot overflow for wide counters.
  localparam longint unsigned MaxCode = (64'd1 << N) - 64'd1;

  // Any MAX_ADDRESS that does not fit in N bits is a configuration error.
  if (N < 1 || MAX_ADDRESS < 0 || longint'(MAX_ADDRESS) > longint'(MaxCode)) begin : g_bad_cfg
    $error("address_counter_n: MAX_ADDRESS=%0d does not fit in N=%0d bits",
           MAX_ADDRESS, N);
  end

  localparam logic [N-1:0] MaxAddr = MAX_ADDRESS[N-1:0];

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  // Next-count selection: wrap, increment, or hold. The wrap test uses >=
  // rather than == so that an out-of-range value (left behind by X or an
  // illegal state) is cleared on the next enabled edge.
  always_comb begin
    count_d = count_q;
    if (d) begin
      if (count_q >= MaxAddr) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Count register. Reset takes priority over d on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign address = count_q;

endmodule

// File: tb/tb_address_counter_n.sv
// Self-checking bench for address_counter_n. Two instances, N=2/MAX=3 and
// N=3/MAX=5, share the same clock and inputs. Each instance is compared with
// a modulo-arithmetic reference model.
module tb_address_counter_n;

  localparam int NA = 2, MA = 3;
  localparam int NB = 3, MB = 5;

  logic          clk;
  logic          rst;
  logic          d;
  logic [NA-1:0] addr_a;
  logic [NB-1:0] addr_b;

  int checks = 0;
  int errors = 0;
  int ref_a  = 0;
  int ref_b  = 0;

  address_counter_n #(.N(NA), .MAX_ADDRESS(MA)) dut_a (
    .clk(clk), .rst(rst), .d(d), .address(addr_a)
  );

  address_counter_n #(.N(NB), .MAX_ADDRESS(MB)) dut_b (
    .clk(clk), .rst(rst), .d(d), .address(addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, update both models from their behavioural
  // rules, and compare both instances with their models after the edge.
  task automatic step(input logic r, input logic en);
    @(negedge clk);
    rst = r;
    d   = en;
    @(posedge clk);
    #1;
    if (!r) begin
      ref_a = 0;
      ref_b = 0;
    end else if (en) begin
      ref_a = (ref_a + 1) % (MA + 1);
      ref_b = (ref_b + 1) % (MB + 1);
    end
    check("model_a", {30'd0, addr_a}, ref_a);
    check("model_b", {29'd0, addr_b}, ref_b);
    check("range_b", {31'd0, (addr_b <= NB'(MB))}, 32'd1);
  endtask

  initial begin
    int seq_a[10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    int seq_b[7]  = '{1, 2, 3, 4, 5, 0, 1};
    rst = 1'b0;
    d   = 1'b0;

    // Reset, then release with d low.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("reset_a", {30'd0, addr_a}, 0);
    check("reset_b", {29'd0, addr_b}, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("release_hold", {30'd0, addr_a}, 0);

    // Single steps with a hold cycle after each.
    for (int v = 1; v <= 3; v++) begin
      step(1'b1, 1'b1);
      check("single_step", {30'd0, addr_a}, v);
      step(1'b1, 1'b0);
      check("single_hold", {30'd0, addr_a}, v);
    end

    // Wrap from 3 to 0, then hold.
    step(1'b1, 1'b1);
    check("wrap", {30'd0, addr_a}, 0);
    step(1'b1, 1'b0);
    check("wrap_hold", {30'd0, addr_a}, 0);

    // Continuous enable for 10 edges.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      check("continuous", {30'd0, addr_a}, seq_a[i]);
    end

    // Reset beats d on the same edge; counting resumes from 0.
    check("pre_rst_prio", {30'd0, addr_a}, 2);
    step(1'b0, 1'b1);
    check("rst_priority", {30'd0, addr_a}, 0);
    step(1'b1, 1'b1);
    check("rst_resume", {30'd0, addr_a}, 1);

    // Non-power-of-two wrap on the N=3/MAX=5 instance.
    step(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1);
      check("npow2_wrap", {29'd0, addr_b}, seq_b[i]);
    end

    // Random stimulus with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) != 0), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
